// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_pkg
// Brief    : Shared commit-trace entry layout {kind, pc, addr, data} and the
//            entry-kind encodings.
// Revision : 1.0 - initial release
// ============================================================================
package trace_pkg;

  localparam logic KIND_GRF = 1'b0;
  localparam logic KIND_DM  = 1'b1;
  localparam int   ENTRY_W  = 97;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  function automatic trace_entry_t make_entry(input logic        kind,
                                              input logic [31:0] pc,
                                              input logic [31:0] addr,
                                              input logic [31:0] data);
    trace_entry_t e;
    e.kind = kind;
    e.pc   = pc;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trace_fifo
// Brief    : Dual-push, single-pop circular buffer of trace entries; the head
//            reads as zero while empty.
// Revision : 1.0 - initial release
// ============================================================================
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push0,
  input  logic [ENTRY_W-1:0]         din0,
  input  logic                       push1,
  input  logic [ENTRY_W-1:0]         din1,
  input  logic                       pop,
  output logic [ENTRY_W-1:0]         dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [PW-1:0]      w_wr_ptr1;

  // The second push lands right behind the first; callers only push what fits.
  assign w_wr_ptr1 = r_wr_ptr + PW'(push0);

  always_ff @(posedge clk) begin
    if (push0) r_mem[r_wr_ptr]  <= din0;
    if (push1) r_mem[w_wr_ptr1] <= din1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(push0) + PW'(push1);
      r_rd_ptr <= r_rd_ptr + PW'(pop);
      r_count  <= r_count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  assign count = r_count;
  assign dout  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/commit_trace.sv
`default_nettype none
// ============================================================================
// Module   : commit_trace
// Brief    : Buffers committed GRF writes and DM stores for a trace consumer.
//            Define COMMIT_TRACE_DROP_CNT_EN to enable the overflow drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module commit_trace
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        grf_we,
  input  logic [31:0] grf_pc,
  input  logic [4:0]  grf_addr,
  input  logic [31:0] grf_data,
  input  logic        dm_we,
  input  logic [31:0] dm_pc,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_kind,
  output logic [31:0] out_pc,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [15:0] drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic               w_grf_ev;
  logic               w_dm_ev;
  logic               w_pop;
  logic               w_grf_acc;
  logic               w_dm_acc;
  logic               w_push0;
  logic               w_push1;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_free;
  trace_entry_t       w_grf_entry;
  trace_entry_t       w_dm_entry;
  trace_entry_t       w_din0;
  trace_entry_t       w_head_s;
  logic [ENTRY_W-1:0] w_head;

  // Writes to $0 are architecturally invisible, so they never reach the buffer.
  assign w_grf_ev  = grf_we && (grf_addr != 5'd0);
  assign w_dm_ev   = dm_we;
  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_free    = CW'(DEPTH) - w_count + CW'(w_pop);

  always_comb begin
    w_grf_acc = 1'b0;
    w_dm_acc  = 1'b0;
    if (w_free >= CW'(2)) begin
      w_grf_acc = w_grf_ev;
      w_dm_acc  = w_dm_ev;
    end else if (w_free == CW'(1)) begin
      w_grf_acc = w_grf_ev;
      w_dm_acc  = w_dm_ev && !w_grf_ev;
    end
  end

  assign w_grf_entry = make_entry(KIND_GRF, grf_pc, {27'd0, grf_addr}, grf_data);
  assign w_dm_entry  = make_entry(KIND_DM, dm_pc, dm_addr, dm_data);
  assign w_push0     = w_grf_acc || w_dm_acc;
  assign w_push1     = w_grf_acc && w_dm_acc;
  assign w_din0      = w_grf_acc ? w_grf_entry : w_dm_entry;

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (w_push0),
    .din0  (w_din0),
    .push1 (w_push1),
    .din1  (w_dm_entry),
    .pop   (w_pop),
    .dout  (w_head),
    .count (w_count)
  );

  assign w_head_s = w_head;
  assign out_kind = w_head_s.kind;
  assign out_pc   = w_head_s.pc;
  assign out_addr = w_head_s.addr;
  assign out_data = w_head_s.data;

`ifdef COMMIT_TRACE_DROP_CNT_EN
  logic [1:0]  w_drops;
  logic [16:0] w_drop_sum;
  logic [15:0] r_drop_cnt;

  assign w_drops    = 2'(w_grf_ev && !w_grf_acc) + 2'(w_dm_ev && !w_dm_acc);
  assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drops);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              r_drop_cnt <= '0;
    else if (w_drop_sum[16]) r_drop_cnt <= 16'hFFFF;
    else                     r_drop_cnt <= w_drop_sum[15:0];
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_commit_trace.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_trace
// Brief    : Scoreboard bench for commit_trace: queue-based reference model,
//            directed scenarios followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_trace;

  localparam int DEPTH = 8;
`ifdef COMMIT_TRACE_DROP_CNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [31:0] out_pc;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  commit_trace #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .grf_we    (grf_we),
    .grf_pc    (grf_pc),
    .grf_addr  (grf_addr),
    .grf_data  (grf_data),
    .dm_we     (dm_we),
    .dm_pc     (dm_pc),
    .dm_addr   (dm_addr),
    .dm_data   (dm_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_pc    (out_pc),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt)
  );

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t   sbq[$];           // entries the DUT still owes the consumer
  int     occ      = 0;     // model occupancy after the latest edge
  int     cyc_occ  = 0;     // occupancy visible during the current cycle
  longint drops    = 0;
  longint cyc_drops = 0;
  bit     in_reset = 1'b1;
  int     vectors  = 0;
  int     miscompares = 0;

  function automatic logic [15:0] exp_dc(input longint d);
    if (!DC_EN) return 16'd0;
    return (d > 65535) ? 16'hFFFF : 16'(d);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
  always @(negedge clk) begin
    if (in_reset) begin
      check("rst_valid", 128'(out_valid), 128'd0);
      check("rst_fields", 128'({out_kind, out_pc, out_addr, out_data}), 128'd0);
      check("rst_drop_cnt", 128'(drop_cnt), 128'd0);
    end else begin
      check("valid", 128'(out_valid), 128'(cyc_occ > 0));
      check("drop_cnt", 128'(drop_cnt), 128'(exp_dc(cyc_drops)));
      if (out_valid) begin
        if (sbq.size() == 0) begin
          check("sb_underflow", 128'd1, 128'd0);
        end else if (out_ready) begin
          check("entry", 128'({out_kind, out_pc, out_addr, out_data}), 128'(sbq[0]));
          void'(sbq.pop_front());
        end else begin
          check("entry_hold", 128'({out_kind, out_pc, out_addr, out_data}), 128'(sbq[0]));
        end
      end else begin
        check("idle_fields", 128'({out_kind, out_pc, out_addr, out_data}), 128'd0);
      end
    end
  end

  // One clock cycle of stimulus plus the reference-model update for it.
  task automatic cyc(input bit gwe, input logic [31:0] gpc, input logic [4:0] ga,
                     input logic [31:0] gd, input bit dwe, input logic [31:0] dpc,
                     input logic [31:0] da, input logic [31:0] dd, input bit rdy);
    ent_t cand[$];
    int   space;
    int   pop;
    @(posedge clk);
    #1;
    cyc_occ   = occ;
    cyc_drops = drops;
    grf_we = gwe; grf_pc = gpc; grf_addr = ga; grf_data = gd;
    dm_we = dwe; dm_pc = dpc; dm_addr = da; dm_data = dd;
    out_ready = rdy;
    if (gwe && ga != 5'd0) cand.push_back('{kind: 1'b0, pc: gpc, addr: {27'd0, ga}, data: gd});
    if (dwe)               cand.push_back('{kind: 1'b1, pc: dpc, addr: da, data: dd});
    pop   = (occ > 0 && rdy) ? 1 : 0;
    space = DEPTH - occ + pop;
    occ   = occ - pop;
    foreach (cand[i]) begin
      if (i < space) begin
        sbq.push_back(cand[i]);
        occ++;
      end else begin
        drops++;
      end
    end
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d, input bit rdy);
    cyc(1, pc, a, d, 0, 0, 0, 0, rdy);
  endtask

  longint d0;

  initial begin
    reset = 1'b0;
    grf_we = 0; grf_pc = 0; grf_addr = 0; grf_data = 0;
    dm_we = 0; dm_pc = 0; dm_addr = 0; dm_data = 0;
    out_ready = 0;
    repeat (2) @(posedge clk);
    #3;
    reset    = 1'b1;
    in_reset = 1'b0;

    // single GRF write, one-cycle latency then empty
    grf(32'h3000, 5'd8, 32'h1234, 1);
    idle(1);
    idle(1);

    // simultaneous GRF and DM: GRF first
    cyc(1, 32'h3004, 5'd2, 32'hAAAA, 1, 32'h3008, 32'h10, 32'hBBBB, 1);
    repeat (3) idle(1);

    // write to $0 is ignored entirely
    grf(32'h300C, 5'd0, 32'hDEAD, 1);
    repeat (2) idle(1);

    // overflow with consumer stalled: 8 kept, 2 dropped
    d0 = drops;
    for (int i = 0; i < 10; i++) grf(32'h4000 + 4 * i, 5'(i + 1), 32'h100 + i, 0);
    idle(0);
    #1;
    check("fill_drop_cnt", 128'(drop_cnt), 128'(exp_dc(d0 + 2)));
    repeat (DEPTH + 2) idle(1);
    check("fill_drained", 128'(sbq.size()), 128'd0);

    // full and draining: GRF takes the freed slot, DM is dropped
    for (int i = 0; i < DEPTH; i++) grf(32'h5000 + 4 * i, 5'd3, 32'h200 + i, 0);
    d0 = drops;
    cyc(1, 32'h6000, 5'd4, 32'h6666, 1, 32'h6004, 32'h20, 32'h7777, 1);
    idle(0);
    #1;
    check("full_drop_cnt", 128'(drop_cnt), 128'(exp_dc(d0 + 1)));
    repeat (DEPTH + 2) idle(1);

    // asynchronous reset with 5 entries buffered
    for (int i = 0; i < 5; i++) grf(32'h7000 + 4 * i, 5'd9, 32'h300 + i, 0);
    idle(0);
    #2;
    reset    = 1'b0;
    in_reset = 1'b1;
    #1;
    check("async_rst_valid", 128'(out_valid), 128'd0);
    sbq.delete();
    occ = 0; cyc_occ = 0; drops = 0; cyc_drops = 0;
    repeat (2) idle(1);
    #3;
    reset    = 1'b1;
    in_reset = 1'b0;
    repeat (3) idle(1);
    grf(32'h8000, 5'd5, 32'h5555, 1);
    repeat (2) idle(1);

    // randomized traffic with alternating consumer pressure
    for (int i = 0; i < 600; i++) begin
      bit         rdy;
      logic [4:0] ga;
      rdy = ((i / 100) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ga  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cyc($urandom_range(0, 1) == 1, $urandom, ga, $urandom,
          $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom, rdy);
    end
    repeat (DEPTH + 2) idle(1);
    check("final_drained", 128'(sbq.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
